bin_to_bcd_seq: RTL
===================

# bin_to_bcd_seq

Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
It processes one input bit per clock, so arithmetic is one correction stage per digit instead of an unrolled BIN_W-deep combinational chain.
It adds valid/ready handshakes on input and output, plus saturation with an overflow flag when the value does not fit in DIGITS decimal digits.
It sits between arithmetic result registers and the seven-segment/display drivers.

## Interface
- BIN_W, 8: width of the unsigned binary input; legal range 1..32.
- DIGITS, 3: number of BCD output digits; legal range 1..10.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  converter can accept a word; high only in IDLE.
- number  in  BIN_W  unsigned binary value, sampled when in_valid && in_ready.
- out_valid  out  1  bcd/overflow hold a completed result.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  packed digits; digit 0 (ones) in [3:0], digit k in [4k+3:4k].
- overflow  out  1  number exceeded 10^DIGITS-1; bcd saturated to all nines.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: load shift register = {4*DIGITS zeros, number}, bit counter = BIN_W, ovf_r = (number > MAX_DEC), then go to SHIFT.
- **SHIFT, each cycle:**
  - Every digit field ≥5 gets +3 (4-bit wrap is impossible after correction).
  - Then shift the whole 4*DIGITS+BIN_W register left by one and decrement the counter.
  - When the counter reaches 0 after the shift, go to DONE.
- **DONE:**
  - out_valid=1.
  - bcd = all-nines if ovf_r, else the upper 4*DIGITS bits of the shift register.
  - overflow = ovf_r.
  - On out_ready, go to IDLE.
  - Outputs are held stable while out_ready=0.
- **Constants:**
  - MAX_DEC = 10^DIGITS-1, computed at elaboration in 64-bit arithmetic.
  - If MAX_DEC ≥ 2^BIN_W-1, overflow is tied to 0.
- **Unsupported inputs:**
  - in_valid outside IDLE is ignored; the source must hold it.
  - number is not re-sampled during conversion.
- **Reset (any state, any cycle):**
  - State returns to IDLE.
  - out_valid=0, bcd=0, overflow=0, counter=0.
  - The in-flight conversion is discarded without a partial result.
  - in_ready=1 while rst_n is low and after release.

## Timing
- Input accepted at rising edge k. SHIFT occupies edges k+1..k+BIN_W. out_valid rises after edge k+BIN_W.
- Latency: BIN_W+1 cycles from accept to first out_valid cycle.
- Result consumed at edge m with out_ready=1. in_ready is high from cycle m+1.
- Max throughput is one word per BIN_W+2 cycles with out_ready tied high.
- No combinational path from inputs to outputs except in_ready (a function of state only).
- Critical path: one 4-bit compare-add per digit plus the shift mux.

## Structure
- **Package bcd_pkg:**
  - FSM state enum: IDLE, SHIFT, DONE.
  - Function max_dec(DIGITS).
  - Constant BCD_NINE = 4'd9.
- **Sub-module bcd_digit_adj:**
  - 4-bit in/out, returns d+3 when d≥5, else d.
  - Instantiated DIGITS times via generate.
- Top contains the FSM, counter ($clog2(BIN_W+1) bits), shift register and overflow register.

## Test plan
- **Max value, 8-bit:** BIN_W=8, DIGITS=3, number=255 → after 9 cycles out_valid=1, bcd=12'h255, overflow=0. Also number=0 → bcd=12'h000.
- **Overflow:** BIN_W=8, DIGITS=2, number=100 → bcd=8'h99, overflow=1. Also number=99 → bcd=8'h99, overflow=0.
- **Back-pressure:** number=137 with out_ready=0 for 5 cycles → bcd=12'h137 and out_valid stay constant, in_ready=0. Release → in_ready=1 next cycle.
- **Reset mid-conversion:** rst_n low for 1 cycle at SHIFT cycle 4 → out_valid=0, bcd=0 immediately. Next word 42 → 12'h042 with normal latency.
- **Wide config:** BIN_W=16, DIGITS=5, number=65535 → bcd=20'h65535 after 17 cycles. Random sweep of 1000 values against a reference model.
- **Back-to-back:** in_valid held high, out_ready=1, words 9, 10, 199 → results 009, 010, 199 in order, spaced BIN_W+2 cycles apart, none dropped.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction stage: a digit of 5 or more gets +3 before the shift.
// Pure combinational, no latency, no flow control.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Bit-serial double-dabble converter, one input bit per cycle; BIN_W+1 cycles accept-to-result.
// Result held stable until out_ready; new words accepted only in IDLE (in_ready = state is IDLE).
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    number,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [63:0]      MAX_DEC  = max_dec(DIGITS);
  localparam logic [63:0]      BIN_MAX  = (64'd1 << BIN_W) - 64'd1;
  // When every BIN_W-bit value fits in DIGITS digits the overflow logic folds away.
  localparam bit               OVF_EN   = (MAX_DEC < BIN_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;
  logic             out_valid_r;
  logic             overflow_r;
  logic [BCD_W-1:0] bcd_r;
  logic             in_ovf;
  logic             unused_adj_msb;

  assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (sr[BIN_W+4*k +: 4]),
      .q (sr_adj[BIN_W+4*k +: 4])
    );
  end

  // The top bit of the corrected register always shifts out; for in-range values it is zero.
  assign sr_next        = {sr_adj[SR_W-2:0], 1'b0};
  assign unused_adj_msb = sr_adj[SR_W-1];

  assign in_ovf = OVF_EN && (64'(number) > MAX_DEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      bcd_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= {{BCD_W{1'b0}}, number};
            cnt   <= CNT_LOAD;
            ovf_r <= in_ovf;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            overflow_r  <= ovf_r;
            bcd_r       <= ovf_r ? {DIGITS{BCD_NINE}} : sr_next[SR_W-1 -: BCD_W];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;
  assign bcd       = bcd_r;

endmodule
